down_timer: RTL and testbench
=============================

Name: down_timer

Overview:
Loadable down-counter/timer and the decrementing counterpart to the team's free-running up counter. Software or a control FSM loads a start value through a valid/ready handshake, starts it, and receives a one-cycle done pulse when the count reaches zero. It supports one-shot and periodic (auto-reload) operation, plus pause and resume. It sits between board-level control logic (buttons, FSM) and LED or 7-segment display drivers.

Parameters:
WIDTH, 8, width of count, reload and load_value
PRESCALE_W, 4, width of prescale input (used only with the optional prescaler)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state
load_valid  input  1  load request
load_ready  output  1  high when a load is accepted this cycle
load_value  input  WIDTH  value written to count and reload on handshake
start  input  1  level-sampled; begin or resume counting
stop  input  1  level-sampled; pause counting
periodic  input  1  1 = auto-reload at terminal count; sampled at terminal tick
prescale  input  PRESCALE_W  tick divider (prescale+1 cycles per decrement)
count  output  WIDTH  current count, registered
busy  output  1  high while in RUN
done  output  1  one-cycle pulse at terminal count

Behaviour:
- Reset (clk edge with reset=1): state=IDLE, count=0, reload=0, done=0, busy=0, prescaler counter=0. Reset overrides every other input, including mid-RUN.
- States: IDLE, RUN, HOLD. busy = (state==RUN), registered.
- load_ready = (state != RUN), combinational from state. Handshake = load_valid & load_ready. On a handshake edge: count<=load_value and reload<=load_value. State does not change.
- IDLE or HOLD with start=1 and stop=0: go to RUN if the effective count is nonzero. Effective count is load_value if a handshake occurs in the same cycle, otherwise count. If the effective count is 0, start is ignored and the state stays unchanged.
- RUN with stop=1: go to HOLD. Count is held; the prescaler counter is held.
- stop and start high in the same cycle: stop wins (RUN->HOLD; IDLE/HOLD stay).
- RUN, tick, count>1: count<=count-1.
- RUN, tick, count==1 (terminal tick): done<=1 for exactly one cycle.
  - If periodic=1 and reload!=0: count<=reload and the state stays RUN. Period = reload ticks.
  - Otherwise: count<=0 and the state goes to IDLE. busy falls on the same edge.
- If stop and the terminal tick coincide: stop wins, no decrement, no done.
- done is low in every other cycle. count never wraps below 0 (no underflow to all-ones).
- tick: without the prescaler, tick=1 every RUN cycle. Latency from the start edge to the first decrement is 1 cycle, so with a load of N, done occurs N cycles after RUN is entered.
- Arithmetic is unsigned WIDTH-bit. reload of all-ones is legal.

Optional Feature:
Macro: DOWN_TIMER_PRESCALE_EN
- Defined: a PRESCALE_W-bit prescaler counter runs only in RUN. tick=1 when prescaler==prescale, then the prescaler reloads to 0; otherwise it increments. The prescaler clears to 0 on every transition into RUN from IDLE (not from HOLD, which resumes). prescale is sampled each cycle.
- Not defined: the prescale port exists but is ignored, and tick=1 every RUN cycle. No prescaler register is synthesized.

Test Plan:
- Reset mid-RUN at count=5 -> next edge count=0, busy=0, done=0, load_ready=1.
- One-shot: load 3, periodic=0, start pulse -> count 3,2,1,0 on successive edges; done high exactly on the cycle count becomes 0; IDLE after; no further decrement.
- Periodic: load 2, periodic=1, hold start -> count 2,1,2,1,...; done every 2 cycles; busy stays 1; load_valid during RUN gives load_ready=0 and count is unaffected.
- Pause and resume: load 4, run 2 ticks, assert stop and start together -> HOLD with count=2; then start alone -> resumes 1,0 with a single done.
- Start with count=0 and no load -> state stays IDLE, busy=0. Load 0 with start in the same cycle -> stays IDLE.
- With DOWN_TIMER_PRESCALE_EN, prescale=2, load 2 -> count decrements every 3 cycles; done 6 cycles after RUN is entered.

Source files
------------

// File: rtl/down_timer.sv
// Loadable down-counter with one-shot/periodic modes, pause/resume and a terminal done pulse.
// Optional tick prescaler is enabled by defining DOWN_TIMER_PRESCALE_EN.
module down_timer #(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_valid,
   output logic                  load_ready,
   input  logic [WIDTH-1:0]      load_value,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  periodic,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic [WIDTH-1:0]      count,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] reload, reload_n, count_n, eff_count;
   logic             done_n, handshake, tick;

   assign load_ready = (state != RUN);
   assign handshake  = load_valid & load_ready;
   assign eff_count  = handshake ? load_value : count;

`ifdef DOWN_TIMER_PRESCALE_EN
   logic [PRESCALE_W-1:0] psc, psc_n;
   assign tick = (psc == prescale);
`else
   logic unused_prescale;
   assign unused_prescale = ^prescale;
   assign tick = 1'b1;
`endif

   always_comb begin
      state_n  = state;
      count_n  = count;
      reload_n = reload;
      done_n   = 1'b0;
`ifdef DOWN_TIMER_PRESCALE_EN
      psc_n    = psc;
`endif
      if (handshake) begin
         count_n  = load_value;
         reload_n = load_value;
      end
      case (state)
         IDLE, HOLD: begin
            if (start && !stop && eff_count != '0) begin
               state_n = RUN;
`ifdef DOWN_TIMER_PRESCALE_EN
               // HOLD resumes mid-period; only a fresh start restarts the divider
               if (state == IDLE) psc_n = '0;
`endif
            end
         end
         RUN: begin
            if (stop) begin
               state_n = HOLD;
            end else begin
`ifdef DOWN_TIMER_PRESCALE_EN
               psc_n = tick ? '0 : psc + PRESCALE_W'(1);
`endif
               if (tick) begin
                  if (count > WIDTH'(1)) begin
                     count_n = count - WIDTH'(1);
                  end else if (count == WIDTH'(1)) begin
                     done_n = 1'b1;
                     if (periodic && reload != '0) begin
                        count_n = reload;
                     end else begin
                        count_n = '0;
                        state_n = IDLE;
                     end
                  end else begin
                     count_n = '0;
                     state_n = IDLE;
                  end
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         count  <= '0;
         reload <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
`ifdef DOWN_TIMER_PRESCALE_EN
         psc    <= '0;
`endif
      end else begin
         state  <= state_n;
         count  <= count_n;
         reload <= reload_n;
         busy   <= (state_n == RUN);
         done   <= done_n;
`ifdef DOWN_TIMER_PRESCALE_EN
         psc    <= psc_n;
`endif
      end
   end

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed literal scenarios plus randomized traffic
// checked every cycle against a behavioural timer model.
module tb_down_timer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       load_valid = 1'b0;
   logic       load_ready;
   logic [7:0] load_value = '0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       periodic = 1'b0;
   logic [3:0] prescale = '0;
   logic [7:0] count;
   logic       busy;
   logic       done;

   down_timer #(.WIDTH(8), .PRESCALE_W(4)) dut (
      .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
      .load_value(load_value), .start(start), .stop(stop), .periodic(periodic),
      .prescale(prescale), .count(count), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2;

   int tests = 0;
   int failed = 0;
   int m_mode = M_IDLE;
   int m_count = 0;
   int m_reload = 0;
   int m_psc = 0;
   bit m_done = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, predict the post-edge outputs, then compare.
   task automatic cycle(input bit rst_i, input bit lv, input int lval, input bit st,
                        input bit sp, input bit per, input int pre);
      int  n_mode, n_count, n_reload, n_psc;
      bit  n_done, hs, tk;
      reset = rst_i; load_valid = lv; load_value = 8'(lval); start = st;
      stop = sp; periodic = per; prescale = 4'(pre);
      n_mode = m_mode; n_count = m_count; n_reload = m_reload; n_psc = m_psc; n_done = 0;
      if (rst_i) begin
         n_mode = M_IDLE; n_count = 0; n_reload = 0; n_psc = 0;
      end else begin
         hs = lv && (m_mode != M_RUN);
         if (hs) begin n_count = lval & 255; n_reload = lval & 255; end
         if (m_mode != M_RUN) begin
            if (st && !sp && (hs ? (lval & 255) : m_count) != 0) begin
               n_mode = M_RUN;
               if (m_mode == M_IDLE) n_psc = 0;
            end
         end else if (sp) begin
            n_mode = M_HOLD;
         end else begin
`ifdef DOWN_TIMER_PRESCALE_EN
            tk = (m_psc == pre);
            n_psc = tk ? 0 : (m_psc + 1) % 16;
`else
            tk = 1'b1;
`endif
            if (tk) begin
               if (m_count > 1) n_count = m_count - 1;
               else begin
                  n_done = (m_count == 1);
                  if (per && m_reload != 0 && m_count == 1) n_count = m_reload;
                  else begin n_count = 0; n_mode = M_IDLE; end
               end
            end
         end
      end
      @(posedge clk); #1;
      m_mode = n_mode; m_count = n_count; m_reload = n_reload; m_psc = n_psc; m_done = n_done;
      chk("count", int'(count), m_count);
      chk("busy", int'(busy), int'(m_mode == M_RUN));
      chk("done", int'(done), int'(m_done));
      chk("load_ready", int'(load_ready), int'(m_mode != M_RUN));
   endtask

   initial begin
      int one_shot[4];
      int per_seq[5];
      int psc_seq[7];
      one_shot = '{3, 2, 1, 0};
      per_seq  = '{2, 1, 2, 1, 2};
      psc_seq  = '{2, 2, 2, 1, 1, 1, 0};

      cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0);
      chk("lit_reset_count", int'(count), 0);
      chk("lit_reset_busy", int'(busy), 0);

      // one-shot: load 3 with start in the same cycle
      cycle(0, 1, 3, 1, 0, 0, 0);
      chk("lit_os_count0", int'(count), one_shot[0]);
      for (int i = 1; i < 4; i++) begin
         cycle(0, 0, 0, 0, 0, 0, 0);
         chk("lit_os_count", int'(count), one_shot[i]);
         chk("lit_os_done", int'(done), int'(i == 3));
      end
      cycle(0, 0, 0, 1, 0, 0, 0);
      chk("lit_os_idle_count", int'(count), 0);
      chk("lit_os_idle_busy", int'(busy), 0);

      // reset mid-run at count 5
      cycle(0, 1, 7, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0);
      chk("lit_mid_count5", int'(count), 5);
      cycle(1, 0, 0, 1, 0, 0, 0);
      chk("lit_mid_rst_count", int'(count), 0);
      chk("lit_mid_rst_busy", int'(busy), 0);
      chk("lit_mid_rst_ready", int'(load_ready), 1);

      // periodic with a blocked load attempted during RUN
      cycle(0, 1, 2, 1, 0, 1, 0);
      for (int i = 1; i < 5; i++) begin
         cycle(0, 1, 9, 1, 0, 1, 0);
         chk("lit_per_count", int'(count), per_seq[i]);
         chk("lit_per_done", int'(done), int'(i == 2 || i == 4));
         chk("lit_per_busy", int'(busy), 1);
         chk("lit_per_ready", int'(load_ready), 0);
      end
      cycle(1, 0, 0, 0, 0, 0, 0);

      // pause and resume
      cycle(0, 1, 4, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 1, 0, 0);
      chk("lit_hold_count", int'(count), 2);
      chk("lit_hold_busy", int'(busy), 0);
      cycle(0, 0, 0, 1, 0, 0, 0);
      chk("lit_resume_busy", int'(busy), 1);
      cycle(0, 0, 0, 0, 0, 0, 0);
      chk("lit_resume_c1", int'(count), 1);
      chk("lit_resume_d1", int'(done), 0);
      cycle(0, 0, 0, 0, 0, 0, 0);
      chk("lit_resume_c0", int'(count), 0);
      chk("lit_resume_d0", int'(done), 1);

      // start on zero count, then load 0 with start
      cycle(0, 0, 0, 1, 0, 0, 0);
      chk("lit_zero_busy", int'(busy), 0);
      cycle(0, 1, 0, 1, 0, 0, 0);
      chk("lit_load0_busy", int'(busy), 0);

      // reload of all-ones in periodic mode
      cycle(0, 1, 255, 1, 0, 1, 0);
      chk("lit_ones_count", int'(count), 255);
      cycle(0, 0, 0, 0, 0, 1, 0);
      chk("lit_ones_dec", int'(count), 254);
      cycle(1, 0, 0, 0, 0, 0, 0);

`ifdef DOWN_TIMER_PRESCALE_EN
      cycle(0, 1, 2, 1, 0, 0, 2);
      for (int i = 1; i < 7; i++) begin
         cycle(0, 0, 0, 0, 0, 0, 2);
         chk("lit_psc_count", int'(count), psc_seq[i]);
         chk("lit_psc_done", int'(done), int'(i == 6));
      end
`else
      cycle(0, 1, 2, 1, 0, 0, 2);
      cycle(0, 0, 0, 0, 0, 0, 2);
      chk("lit_nopsc_count", int'(count), psc_seq[6] + 1);
`endif

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         int lval;
         lval = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                            : int'($urandom_range(0, 6));
         cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, lval,
               $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
               1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
